// File: rtl/fpu_mul_pipe.sv
// fpu_mul_pipe: three-stage pipelined floating-point multiplier with valid/ready
// on both sides. Stage 1 unpacks and classifies, stage 2 multiplies the
// significands, stage 3 normalises, rounds to nearest-even and packs.
// Subnormal operands are flushed to zero and results never go subnormal.
// Optional build macro FPU_MUL_STICKY_FLAGS_EN turns o_flags into a sticky
// accumulator with a synchronous clear input i_flag_clr.
module fpu_mul_pipe #(
   parameter  int EXP_W     = 8,
   parameter  int MAN_W     = 23,
   localparam int SIZE_DATA = 1 + EXP_W + MAN_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [SIZE_DATA-1:0] i_a,
   input  logic [SIZE_DATA-1:0] i_b,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [SIZE_DATA-1:0] o_mul,
   output logic [3:0]           o_flags
`ifdef FPU_MUL_STICKY_FLAGS_EN
   ,
   input  logic                 i_flag_clr
`endif
);

   localparam int EW = EXP_W + 2;       // exponent width with sign/overflow headroom
   localparam int PW = 2 * MAN_W + 2;   // full significand product width
   localparam logic [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

   typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

   logic en, in_fire, rst_done;

   assign en      = i_ready | ~o_valid;
   assign o_ready = en & rst_done;
   assign in_fire = i_valid & o_ready;

   // ---------------- stage 1: unpack / classify ----------------
   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W-1:0] man_a, man_b;
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic inf_zero;
   kind_t kind_in;
   logic  inv_in;

   assign exp_a  = i_a[SIZE_DATA-2 -: EXP_W];
   assign exp_b  = i_b[SIZE_DATA-2 -: EXP_W];
   assign man_a  = i_a[MAN_W-1:0];
   assign man_b  = i_b[MAN_W-1:0];
   assign a_zero = (exp_a == '0);          // subnormals flush to zero here
   assign b_zero = (exp_b == '0);
   assign a_inf  = (&exp_a) & (man_a == '0);
   assign b_inf  = (&exp_b) & (man_b == '0);
   assign a_nan  = (&exp_a) & (|man_a);
   assign b_nan  = (&exp_b) & (|man_b);
   assign a_snan = a_nan & ~man_a[MAN_W-1];
   assign b_snan = b_nan & ~man_b[MAN_W-1];
   assign inf_zero = (a_inf & b_zero) | (b_inf & a_zero);

   // Classify the operand pair into the special-case result it produces.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      kind_in = K_NUM;
      inv_in  = 1'b0;
      if (a_nan | b_nan | inf_zero) begin
         kind_in = K_NAN;
         inv_in  = a_snan | b_snan | inf_zero;
      end else if (a_inf | b_inf) begin
         kind_in = K_INF;
      end else if (a_zero | b_zero) begin
         kind_in = K_ZERO;
      end
   end

   logic             s1_valid, s1_sign, s1_inv;
   kind_t            s1_kind;
   logic [EW-1:0]    s1_exp;
   logic [MAN_W:0]   s1_man_a, s1_man_b;

   logic             s2_valid, s2_sign, s2_inv;
   kind_t            s2_kind;
   logic [EW-1:0]    s2_exp;
   logic [PW-1:0]    s2_prod;

   logic [3:0]       out_flags;

   // ---------------- stage 3: normalise / round / pack ----------------
   logic                 msb, guard, sticky, round_up;
   logic [PW-2:0]        frac;
   logic [MAN_W-1:0]     man_t;
   logic [MAN_W:0]       man_r;
   logic [EW-1:0]        exp_f;
   logic [SIZE_DATA-1:0] res;
   logic [3:0]           res_flags;

   assign msb      = s2_prod[PW-1];
   assign frac     = msb ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
   assign man_t    = frac[PW-2 -: MAN_W];
   assign guard    = frac[MAN_W];
   assign sticky   = |frac[MAN_W-1:0];
   assign round_up = guard & (sticky | man_t[0]);
   assign man_r    = {1'b0, man_t} + (MAN_W + 1)'(round_up);
   assign exp_f    = s2_exp + EW'(msb) + EW'(man_r[MAN_W]);

   // Select the packed result and its flags; range checks use the final exponent.
   always_comb begin
      res       = '0;
      res_flags = '0;
      case (s2_kind)
         K_NAN: begin
            res       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
            res_flags = {s2_inv, 3'b000};
         end
         K_INF:  res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         K_ZERO: res = {s2_sign, {(EXP_W + MAN_W){1'b0}}};
         default: begin
            if (!exp_f[EW-1] && exp_f >= EXP_MAX) begin
               res       = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               res_flags = 4'b0101;
            end else if (exp_f[EW-1] || exp_f == '0) begin
               res       = {s2_sign, {(EXP_W + MAN_W){1'b0}}};
               res_flags = 4'b0011;
            end else begin
               res       = {s2_sign, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
               res_flags = {3'b000, guard | sticky};
            end
         end
      endcase
   end

   // Input acceptance is held off until the first clock after reset release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rst_done <= 1'b0;
      else          rst_done <= 1'b1;
   end

   // Stage valid bits and the output register; all stages advance together on en.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: sequential state uses non-blocking assignments only.
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         o_valid   <= 1'b0;
         o_mul     <= '0;
         out_flags <= '0;
      end else if (en) begin
         s1_valid <= in_fire;
         s2_valid <= s1_valid;
         o_valid  <= s2_valid;
         if (s2_valid) begin
            o_mul     <= res;
            out_flags <= res_flags;
         end
      end
   end

   // Stage payloads load only alongside a valid token.
   // NOTE: payload registers are qualified by the valid bits, so they need no reset.
   always_ff @(posedge i_clk) begin
      if (in_fire) begin
         s1_sign  <= i_a[SIZE_DATA-1] ^ i_b[SIZE_DATA-1];
         s1_kind  <= kind_in;
         s1_inv   <= inv_in;
         s1_exp   <= {2'b00, exp_a} + {2'b00, exp_b} - BIAS;
         s1_man_a <= {1'b1, man_a};
         s1_man_b <= {1'b1, man_b};
      end
      if (en && s1_valid) begin
         s2_sign <= s1_sign;
         s2_kind <= s1_kind;
         s2_inv  <= s1_inv;
         s2_exp  <= s1_exp;
         s2_prod <= PW'(s1_man_a) * PW'(s1_man_b);
      end
   end

`ifdef FPU_MUL_STICKY_FLAGS_EN
   logic [3:0] sticky_q;

   // Accumulate flags of transferred results; a same-cycle clear keeps only the new ones.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                sticky_q <= '0;
      else if (o_valid && i_ready) sticky_q <= (i_flag_clr ? 4'b0000 : sticky_q) | out_flags;
      else if (i_flag_clr)         sticky_q <= '0;
   end

   assign o_flags = sticky_q;
`else
   assign o_flags = o_valid ? out_flags : 4'b0000;
`endif

endmodule
